// File: rtl/countdown_timer.sv
// BCD countdown timer with run/pause control, miss penalties and a
// multiplexed active-low 7-segment display driver.
module countdown_timer #(
  parameter int DIGITS    = 8,
  parameter int TICK_DIV  = 5000,
  parameter int PEN_DIGIT = 1,
  parameter int DP_POS    = 4,
  parameter int SCAN_BITS = 14
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  input  logic                  start_i,
  input  logic                  miss_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  running_o,
  output logic                  fail_o,
  output logic                  expired_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o
);

  localparam int CW    = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W:0] DIG_CNT = (IDX_W+1)'(DIGITS);
  localparam logic [IDX_W:0] DP_IDX  = (IDX_W+1)'(DP_POS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            pend_q, pend_d;
  logic            fail_q, fail_d;
  logic            expired_q, expired_d;
  logic            running_q, running_d;
  logic            init_q;
  logic            miss_s1_q, miss_s2_q;
  logic [SCAN_BITS-1:0] scan_q;

  logic            tick, miss_edge, dec;
  logic [CW-1:0]   adj;
  logic            pend_adj;

  // Subtract 10^k with borrow rippling upward from digit k; saturate at 0
  // when every digit at or above k is already zero.
  function automatic logic [CW-1:0] bcd_sub_pow(input logic [CW-1:0] v, input int k);
    logic [CW-1:0] r;
    logic          borrow;
    logic          upper_zero;
    r          = v;
    borrow     = 1'b1;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (i >= k && v[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    if (upper_zero) begin
      r = '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i >= k && borrow) begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick      = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
    miss_edge = miss_s1_q & ~miss_s2_q;
    dec       = pend_q | tick;
    // A penalty wins the datapath; a coincident decrement waits in pend.
    if (miss_edge) begin
      adj      = bcd_sub_pow(count_q, PEN_DIGIT);
      pend_adj = dec;
    end else if (dec) begin
      adj      = bcd_sub_pow(count_q, 0);
      pend_adj = pend_q & tick;
    end else begin
      adj      = count_q;
      pend_adj = pend_q;
    end

    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    pend_d    = pend_q;
    fail_d    = fail_q;
    expired_d = 1'b0;

    if (init_q || load_i) begin
      state_d = IDLE;
      count_d = load_value_i;
      presc_d = '0;
      pend_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          if (start_i) state_d = RUN;
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (count_q == '0) begin
            state_d   = EXPIRED;
            expired_d = 1'b1;
            fail_d    = 1'b1;
            pend_d    = 1'b0;
          end else begin
            count_d = adj;
            pend_d  = pend_adj;
            if (adj == '0) begin
              state_d   = EXPIRED;
              expired_d = 1'b1;
              fail_d    = 1'b1;
              pend_d    = 1'b0;
            end else if (!start_i) begin
              state_d = PAUSED;
            end
          end
        end
        PAUSED: begin
          count_d = adj;
          pend_d  = pend_adj;
          if (start_i) state_d = RUN;
        end
        default: begin
          presc_d = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  // init_q makes the first edge after reset release sample load_value_i.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      pend_q    <= 1'b0;
      fail_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      init_q    <= 1'b1;
      miss_s1_q <= 1'b0;
      miss_s2_q <= 1'b0;
      scan_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pend_q    <= pend_d;
      fail_q    <= fail_d;
      expired_q <= expired_d;
      running_q <= running_d;
      init_q    <= 1'b0;
      miss_s1_q <= miss_i;
      miss_s2_q <= miss_s1_q;
      scan_q    <= scan_q + SCAN_BITS'(1);
    end
  end

  logic [IDX_W-1:0] idx_raw, idx;
  logic [3:0]       digit;

  always_comb begin
    idx_raw = scan_q[SCAN_BITS-1 -: IDX_W];
    idx     = idx_raw;
    if ({1'b0, idx_raw} >= DIG_CNT) idx = idx_raw - IDX_W'(DIGITS);
    digit = count_q[4*idx +: 4];
    an_o  = ~(DIGITS'(1) << idx);
    seg_o = seg_decode(digit);
    dp_o  = ({1'b0, idx} == DP_IDX) ? 1'b0 : 1'b1;
  end

  assign value_o   = count_q;
  assign running_o = running_q;
  assign fail_o    = fail_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a decimal-integer reference model
// queues per-cycle expectations, a monitor compares them after each edge.
module tb_countdown_timer;

  localparam int DIGITS = 4;
  localparam int TD     = 4;
  localparam int SB     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic        start = 1'b0;
  logic        miss = 1'b0;
  logic [15:0] value;
  logic        running, fail, expired, dp;
  logic [6:0]  seg;
  logic [3:0]  an;

  countdown_timer #(
    .DIGITS(DIGITS), .TICK_DIV(TD), .PEN_DIGIT(1), .DP_POS(2), .SCAN_BITS(SB)
  ) dut (
    .clock_i(clk), .reset_i(rst), .load_i(load), .load_value_i(load_value),
    .start_i(start), .miss_i(miss), .value_o(value), .running_o(running),
    .fail_o(fail), .expired_o(expired), .seg_o(seg), .dp_o(dp), .an_o(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        running;
    logic        fail;
    logic        expired;
    logic [3:0]  an;
    logic        dp;
    logic [6:0]  seg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: count held as a plain decimal integer.
  int m_state;  // 0 idle, 1 run, 2 paused, 3 expired
  int m_count, m_phase, m_scan;
  bit m_pend, m_fail, m_exp, m_init, m_h1, m_h2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    int s = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_phase = 0; m_scan = 0;
    m_pend = 0; m_fail = 0; m_exp = 0; m_init = 1; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic expire();
    m_state = 3; m_exp = 1; m_fail = 1; m_pend = 0;
  endtask

  task automatic apply(input bit tick, input bit ev);
    if (ev) begin
      m_count = (m_count < 10) ? 0 : m_count - 10;
      m_pend  = tick || m_pend;
    end else if (tick || m_pend) begin
      if (m_count > 0) m_count = m_count - 1;
      m_pend = 0;
    end
  endtask

  task automatic model_step(input bit ld, input logic [15:0] lv, input bit st, input bit ms);
    bit ev;
    bit tick;
    ev = m_h1 && !m_h2;
    m_h2 = m_h1; m_h1 = ms;
    m_scan = (m_scan + 1) % (1 << SB);
    m_exp = 0;
    if (ld || m_init) begin
      m_init = 0; m_state = 0; m_count = bcd2int(lv);
      m_phase = 0; m_pend = 0; m_fail = 0;
    end else begin
      case (m_state)
        0: begin m_phase = 0; if (st) m_state = 1; end
        1: begin
          tick = (m_phase == TD - 1);
          m_phase = (m_phase + 1) % TD;
          if (m_count == 0) expire();
          else begin
            apply(tick, ev);
            if (m_count == 0) expire();
            else if (!st) m_state = 2;
          end
        end
        2: begin apply(1'b0, ev); if (st) m_state = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int   idx;
    idx = m_scan / (1 << (SB - 2));
    e.value   = int2bcd(m_count);
    e.running = (m_state == 1);
    e.fail    = m_fail;
    e.expired = m_exp;
    e.an      = ~(4'b0001 << idx);
    e.dp      = (idx == 2) ? 1'b0 : 1'b1;
    e.seg     = seg_of((m_count / (10 ** idx)) % 10);
    q.push_back(e);
  endtask

  task automatic cyc(input bit ld, input logic [15:0] lv, input bit st, input bit ms);
    @(negedge clk);
    rst = 0; load = ld; load_value = lv; start = st; miss = ms;
    model_step(ld, lv, st, ms);
    push_expect();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; load = 0; start = 0; miss = 0;
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_fail", 32'(fail), 32'h0);
    chk("rst_expired", 32'(expired), 32'h0);
    chk("rst_an", 32'(an), 32'he);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_seg", 32'(seg), 32'h40);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_value", 32'(value), 32'h0);
    chk("rst_hold_an", 32'(an), 32'he);
    model_reset();
  endtask

  // Monitor: outputs are valid every cycle; pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("value", 32'(value), 32'(e.value));
        chk("running", 32'(running), 32'(e.running));
        chk("fail", 32'(fail), 32'(e.fail));
        chk("expired", 32'(expired), 32'(e.expired));
        chk("an", 32'(an), 32'(e.an));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("seg", 32'(seg), 32'(e.seg));
      end
    end
  end

  initial begin
    logic [15:0] lv;
    bit st, ms;
    model_reset();

    // Plain countdown to expiry
    do_reset();
    cyc(0, 16'h0012, 0, 0);
    cyc(1, 16'h0012, 0, 0);
    repeat (55) cyc(0, 16'h0012, 1, 0);

    // Single penalty from 0100
    cyc(1, 16'h0100, 0, 0);
    repeat (6) cyc(0, 16'h0100, 1, 0);
    repeat (3) cyc(0, 16'h0100, 1, 1);
    repeat (10) cyc(0, 16'h0100, 1, 0);

    // Penalty saturates to zero, then expired is inert
    cyc(1, 16'h0005, 0, 0);
    repeat (3) cyc(0, 16'h0005, 1, 0);
    repeat (2) cyc(0, 16'h0005, 1, 1);
    for (int i = 0; i < 12; i++) cyc(0, 16'h0005, i[1], i[0]);

    // Penalty coincident with a tick at 0020
    cyc(1, 16'h0020, 0, 0);
    repeat (3) cyc(0, 16'h0020, 1, 0);
    repeat (2) cyc(0, 16'h0020, 1, 1);
    repeat (6) cyc(0, 16'h0020, 1, 0);

    // Pause and resume
    cyc(1, 16'h0050, 0, 0);
    repeat (9) cyc(0, 16'h0050, 1, 0);
    repeat (20) cyc(0, 16'h0050, 0, 0);
    repeat (12) cyc(0, 16'h0050, 1, 0);

    // Zero load: one RUN cycle then expiry
    cyc(1, 16'h0000, 0, 0);
    repeat (3) cyc(0, 16'h0000, 1, 0);

    // Reset mid-run, then display scan of 0910
    cyc(1, 16'h0100, 0, 0);
    repeat (5) cyc(0, 16'h0100, 1, 0);
    do_reset();
    cyc(0, 16'h0910, 0, 0);
    cyc(1, 16'h0910, 0, 0);
    repeat (20) cyc(0, 16'h0910, 0, 0);

    // Randomized traffic
    lv = 16'h0030; st = 0; ms = 0;
    cyc(1, lv, st, ms);
    for (int i = 0; i < 800; i++) begin
      bit ld;
      ld = ($urandom_range(0, 49) == 0);
      if (ld) lv = int2bcd($urandom_range(0, ($urandom_range(0, 1) == 1) ? 60 : 9999));
      if ($urandom_range(0, 11) == 0) st = !st;
      if ($urandom_range(0, 4) == 0) ms = !ms;
      cyc(ld, lv, st, ms);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
